// File: rtl/lsu_mem_adapter.sv
// Single-outstanding load/store adapter from the LSU to a req/ready memory bus.
// Handles lane placement, load extraction/extension, alignment checks and a bus watchdog.
module lsu_mem_adapter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  output logic                  lsu_rsp_valid,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_err,
  output logic [1:0]            lsu_err_code,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_mem_adapter supports DATA_WIDTH = 32 only");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  state_t           state;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [CNT_W-1:0] cnt;

  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign lsu_ready   = (state == IDLE);
  assign misaligned  = ((lsu_size == 2'b01) && lsu_addr[0]) ||
                       ((lsu_size == 2'b10) && (lsu_addr[1:0] != 2'b00));
  assign timeout_hit = WD_EN && (cnt == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    be_lane    = 4'b1111;
    wdata_lane = lsu_wdata;
    case (lsu_size)
      2'b00: begin
        be_lane    = 4'b0001 << lsu_addr[1:0];
        wdata_lane = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_lane    = 4'b0011 << lsu_addr[1:0];
        wdata_lane = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!lsu_we) wdata_lane = '0;
  end

  // Load data arrives on its natural lanes; right-justify, then extend.
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lsu_rsp_valid <= 1'b0;
      lsu_rdata     <= '0;
      lsu_err       <= 1'b0;
      lsu_err_code  <= ERR_NONE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      cnt           <= '0;
    end else begin
      lsu_rsp_valid <= 1'b0;
      lsu_rdata     <= '0;
      lsu_err       <= 1'b0;
      lsu_err_code  <= ERR_NONE;
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            if (lsu_size == 2'b11) begin
              state         <= RESP;
              lsu_rsp_valid <= 1'b1;
              lsu_err       <= 1'b1;
              lsu_err_code  <= ERR_SIZE;
            end else if (misaligned) begin
              state         <= RESP;
              lsu_rsp_valid <= 1'b1;
              lsu_err       <= 1'b1;
              lsu_err_code  <= ERR_MISALIGN;
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= wdata_lane;
              mem_be    <= be_lane;
              off_q     <= lsu_addr[1:0];
              size_q    <= lsu_size;
              uns_q     <= lsu_unsigned;
              cnt       <= '0;
            end
          end
        end
        BUSY: begin
          // A ready in the same cycle as the final watchdog count completes normally.
          if (mem_ready || timeout_hit) begin
            state         <= RESP;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            lsu_rsp_valid <= 1'b1;
            if (mem_ready) begin
              lsu_rdata <= mem_we ? 32'd0 : load_data;
            end else begin
              lsu_err      <= 1'b1;
              lsu_err_code <= ERR_TIMEOUT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter: directed vector table, hand-written
// watchdog/reset sequences, and random transactions against a byte-level model.
module tb_lsu_mem_adapter;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic [1:0]  lsu_err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Second instance with a short watchdog; shares data inputs, own valid/ready.
  logic        wd_valid;
  logic        wd_ready;
  logic        wd_rsp_valid;
  logic [31:0] wd_rdata;
  logic        wd_err;
  logic [1:0]  wd_err_code;
  logic        wd_mem_req;
  logic        wd_mem_we;
  logic [31:0] wd_mem_addr;
  logic [31:0] wd_mem_wdata;
  logic [3:0]  wd_mem_be;
  logic        wd_mem_ready;

  int checks   = 0;
  int failures = 0;

  lsu_mem_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .lsu_err_code(lsu_err_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  lsu_mem_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_wd (
    .clk(clk), .rst(rst),
    .lsu_valid(wd_valid), .lsu_ready(wd_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_rsp_valid(wd_rsp_valid),
    .lsu_rdata(wd_rdata), .lsu_err(wd_err), .lsu_err_code(wd_err_code),
    .mem_req(wd_mem_req), .mem_we(wd_mem_we), .mem_addr(wd_mem_addr),
    .mem_wdata(wd_mem_wdata), .mem_be(wd_mem_be), .mem_rdata(mem_rdata),
    .mem_ready(wd_mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          delay;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rsp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic vec_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                                 input int delay);
    vec_t   v;
    int     nbytes;
    int     off;
    longint mask;
    longint val;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.rdata = rdata; v.delay = delay;
    nbytes = 1 << size;
    off    = int'(addr % 4);
    if (size == 2'd3)            v.code = 2'd2;
    else if (off % nbytes != 0)  v.code = 2'd1;
    else                         v.code = 2'd0;
    v.be = 4'(((1 << nbytes) - 1) << off);
    v.mwdata = '0;
    if (we)
      for (int b = 0; b < 4; b++) v.mwdata[8*b +: 8] = wdata[8*(b % nbytes) +: 8];
    v.rsp = '0;
    if (!we && v.code == 2'd0) begin
      mask = (64'd1 << (8 * nbytes)) - 1;
      val  = longint'(rdata >> (8 * off)) & mask;
      if (!uns && ((val >> (8 * nbytes - 1)) & 1) == 1) val = val | ~mask;
      v.rsp = val[31:0];
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    check("idle_ready", lsu_ready, 1'b1);
    lsu_valid = 1'b1; lsu_we = v.we; lsu_addr = v.addr; lsu_wdata = v.wdata;
    lsu_size = v.size; lsu_unsigned = v.uns;
    @(posedge clk);
    #1 lsu_valid = 1'b0;
    lsu_wdata = $urandom; lsu_addr = $urandom;
    if (v.code != 2'd0) begin
      @(negedge clk);
      check("err_no_req", mem_req, 1'b0);
      check("err_rsp_valid", lsu_rsp_valid, 1'b1);
      check("err_flag", lsu_err, 1'b1);
      check("err_code", lsu_err_code, v.code);
      check("err_rdata", lsu_rdata, 32'd0);
    end else begin
      for (int i = 0; i <= v.delay; i++) begin
        @(negedge clk);
        check("busy_req", mem_req, 1'b1);
        check("busy_we", mem_we, v.we);
        check("busy_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        check("busy_be", mem_be, v.be);
        check("busy_wdata", mem_wdata, v.mwdata);
        check("busy_no_rsp", lsu_rsp_valid, 1'b0);
        check("busy_not_ready", lsu_ready, 1'b0);
        mem_ready = (i == v.delay);
        mem_rdata = (i == v.delay) ? v.rdata : $urandom;
      end
      @(posedge clk);
      #1 mem_ready = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      check("rsp_valid", lsu_rsp_valid, 1'b1);
      check("rsp_err", lsu_err, 1'b0);
      check("rsp_code", lsu_err_code, 2'd0);
      check("rsp_rdata", lsu_rdata, v.rsp);
      check("rsp_req_low", mem_req, 1'b0);
    end
    check("rsp_not_ready", lsu_ready, 1'b0);
    @(negedge clk);
    check("rsp_single_pulse", lsu_rsp_valid, 1'b0);
    check("rsp_rdata_clear", lsu_rdata, 32'd0);
    check("back_idle", lsu_ready, 1'b1);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    rst = 1'b1; lsu_valid = 1'b0; wd_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0;
    lsu_wdata = '0; lsu_size = 2'b10; lsu_unsigned = 1'b0; mem_rdata = '0;
    mem_ready = 1'b0; wd_mem_ready = 1'b0;

    //            we    addr          wdata         sz     uns   rdata         dly code  be       mwdata        rsp
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 0, 2'd0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h0000_0103, 32'h0,        2'b00, 1'b0, 32'h80123456, 0, 2'd0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{1'b0, 32'h0000_0103, 32'h0,        2'b00, 1'b1, 32'h80123456, 1, 2'd0, 4'b1000, 32'h0,        32'h00000080};
    vecs[3] = '{1'b1, 32'h0000_0202, 32'hA5A5BEEF, 2'b01, 1'b0, 32'h0,        5, 2'd0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0001, 32'h0,        2'b01, 1'b0, 32'h0,        0, 2'd1, 4'b0000, 32'h0,        32'h0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,        2'b11, 1'b0, 32'h0,        0, 2'd2, 4'b0000, 32'h0,        32'h0};
    vecs[6] = '{1'b0, 32'h0000_0302, 32'h0,        2'b01, 1'b0, 32'h80011234, 2, 2'd0, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[7] = '{1'b1, 32'h0000_0401, 32'h12345655, 2'b00, 1'b0, 32'h0,        0, 2'd0, 4'b0010, 32'h55555555, 32'h0};

    #2;
    check("rst_ready", lsu_ready, 1'b1);
    check("rst_rsp_valid", lsu_rsp_valid, 1'b0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_err", {lsu_err, lsu_err_code}, 3'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", mem_be, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Watchdog abort: req held exactly 4 cycles, then timeout response.
    @(negedge clk);
    wd_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h40; lsu_size = 2'b10; lsu_unsigned = 1'b0;
    @(posedge clk);
    #1 wd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wd_req_held", wd_mem_req, 1'b1);
      check("wd_no_rsp", wd_rsp_valid, 1'b0);
    end
    @(negedge clk);
    check("wd_req_dropped", wd_mem_req, 1'b0);
    check("wd_rsp_valid", wd_rsp_valid, 1'b1);
    check("wd_err", wd_err, 1'b1);
    check("wd_code", wd_err_code, 2'd3);
    check("wd_rdata", wd_rdata, 32'd0);
    @(negedge clk);
    check("wd_pulse_end", wd_rsp_valid, 1'b0);

    // Ready on the final count wins over the watchdog.
    @(negedge clk);
    wd_valid = 1'b1; lsu_addr = 32'h44;
    @(posedge clk);
    #1 wd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wd2_req_held", wd_mem_req, 1'b1);
      if (i == 3) begin
        wd_mem_ready = 1'b1;
        mem_rdata    = 32'h1357_9BDF;
      end
    end
    @(posedge clk);
    #1 wd_mem_ready = 1'b0;
    @(negedge clk);
    check("wd2_rsp_valid", wd_rsp_valid, 1'b1);
    check("wd2_err", wd_err, 1'b0);
    check("wd2_code", wd_err_code, 2'd0);
    check("wd2_rdata", wd_rdata, 32'h1357_9BDF);
    check("wd2_req_low", wd_mem_req, 1'b0);

    // Reset during BUSY: req drops immediately, no response afterwards.
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500; lsu_size = 2'b10;
    @(posedge clk);
    #1 lsu_valid = 1'b0;
    @(negedge clk);
    check("mid_req_c1", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_ready", lsu_ready, 1'b1);
    check("mid_rst_rsp", lsu_rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", lsu_rsp_valid, 1'b0);
      check("post_rst_no_req", mem_req, 1'b0);
    end
    run_txn(model(1'b1, 32'h0000_0600, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1));

    // Random transactions, including stray mem_ready pulses while idle.
    for (int n = 0; n < 60; n++) begin
      rv = model(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom), $urandom, $urandom_range(0, 4));
      mem_ready = 1'($urandom);
      run_txn(rv);
      mem_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
